// File: rtl/spi_slave_regs_pkg.sv
// spi_pkg: shared FSM states, frame geometry and SCLK edge selection for spi_slave_regs
package spi_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_BYTE_BITS = 8;
  // 1 when MOSI is sampled on the rising SCLK edge, 0 when on the falling edge
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol ~^ cpha;
  endfunction
endpackage

// File: rtl/spi_slave_regs_if.sv
// spi_slave_regs_if: SPI pins plus register-file strobe bus of spi_slave_regs
interface spi_slave_regs_if;
  logic SCLK;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic miso_oe;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic wr_en;
  logic rd_en;
  logic err;
  modport master (output SCLK, SS_n, MOSI, rdata, input MISO, miso_oe, addr, wdata, wr_en, rd_en, err);
  modport slave (input SCLK, SS_n, MOSI, rdata, output MISO, miso_oe, addr, wdata, wr_en, rd_en, err);
endinterface

// File: rtl/spi_slave_regs_sync_edge.sv
// spi_sync_edge: two-flop synchronizer with rise/fall detect on the synchronized level
module spi_sync_edge #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [1:0] sync;
  logic prev;
  always_ff @(posedge clk)
    if (!rst_n) begin
      sync <= {2{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[0], d};
      prev <= sync[1];
    end
  assign level = sync[1];
  assign rise = sync[1] && !prev;
  assign fall = !sync[1] && prev;
endmodule

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI slave turning 16-bit frames into register write/read strobes.
// Read frames (rd_en, MISO shift-out) exist only when SPI_SLAVE_READ_EN is defined.
module spi_slave_regs
  import spi_pkg::*;
#(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input logic PCLK,
  input logic PRESETn,
  spi_slave_regs_if.slave bus
);
`ifdef SPI_SLAVE_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif
  localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  state_t state_q, state_d;
  logic sclk_rise, sclk_fall, ss_lvl, ss_fall, mosi;
  logic unused_sclk_lvl, unused_ss_rise, unused_mosi_rise, unused_mosi_fall;
  logic sample, shift, rw, overrun, armed;
  logic wr_d, rd_d, err_d;
  logic [1:0] warm;
  logic [3:0] cnt;
  logic [7:0] sr;
  spi_sync_edge #(.RST_VAL(CPOL)) u_sclk (.clk(PCLK), .rst_n(PRESETn), .d(bus.SCLK),
    .level(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_ss (.clk(PCLK), .rst_n(PRESETn), .d(bus.SS_n),
    .level(ss_lvl), .rise(unused_ss_rise), .fall(ss_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (.clk(PCLK), .rst_n(PRESETn), .d(bus.MOSI),
    .level(mosi), .rise(unused_mosi_rise), .fall(unused_mosi_fall));
  assign sample = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift = SAMPLE_RISE ? sclk_fall : sclk_rise;
  assign bus.miso_oe = !ss_lvl;
  always_comb begin
    state_d = state_q;
    wr_d = 1'b0;
    rd_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: state_d = (ss_fall && armed) ? ADDR : IDLE;
      ADDR:
        if (sample && cnt == 4'(SPI_BYTE_BITS - 1)) begin
          state_d = DATA;
          rd_d = READ_EN && sr[6];
        end else if (ss_lvl) begin
          state_d = IDLE;
          err_d = 1'b1;
        end
      DATA:
        if (sample && cnt == 4'(SPI_FRAME_BITS - 1)) begin
          state_d = DONE;
          wr_d = !rw;
        end else if (ss_lvl) begin
          state_d = IDLE;
          err_d = 1'b1;
        end
      default:
        if (ss_lvl) begin
          state_d = IDLE;
          err_d = overrun || (rw && !READ_EN);
        end
    endcase
  end
  // after reset SS_n must be seen high before a fall can open a frame
  always_ff @(posedge PCLK)
    if (!PRESETn) begin
      state_q <= IDLE;
      bus.wr_en <= 1'b0;
      bus.err <= 1'b0;
      warm <= '0;
      armed <= 1'b0;
    end else begin
      state_q <= state_d;
      bus.wr_en <= wr_d;
      bus.err <= err_d;
      warm <= {warm[0], 1'b1};
      armed <= armed || (warm[1] && ss_lvl);
    end
  always_ff @(posedge PCLK)
    if (!PRESETn) begin
      cnt <= '0;
      sr <= '0;
      rw <= 1'b0;
      overrun <= 1'b0;
      bus.addr <= '0;
      bus.wdata <= '0;
    end else begin
      if (state_q == IDLE) begin
        cnt <= '0;
        overrun <= 1'b0;
      end
      if (sample && (state_q == ADDR || state_q == DATA)) begin
        cnt <= cnt + 4'd1;
        sr <= {sr[6:0], mosi};
      end
      if (state_q == ADDR && state_d == DATA) begin
        rw <= sr[6];
        bus.addr <= {sr[5:0], mosi};
      end
      if (wr_d) bus.wdata <= {sr[6:0], mosi};
      if (sample && state_q == DONE) overrun <= 1'b1;
    end
`ifdef SPI_SLAVE_READ_EN
  logic rd_q;
  logic [7:0] tx;
  always_ff @(posedge PCLK)
    if (!PRESETn) begin
      rd_q <= 1'b0;
      tx <= '0;
      bus.rd_en <= 1'b0;
      bus.MISO <= 1'b0;
    end else begin
      bus.rd_en <= rd_d;
      rd_q <= bus.rd_en;
      if (rd_q) tx <= bus.rdata;
      else if (shift && state_q == DATA && rw) tx <= {tx[6:0], 1'b0};
      if (state_q == IDLE) bus.MISO <= 1'b0;
      else if (shift && state_q == DATA && rw) bus.MISO <= tx[7];
    end
`else
  logic unused_rd;
  assign unused_rd = rd_d ^ shift ^ (^bus.rdata);
  assign bus.rd_en = 1'b0;
  assign bus.MISO = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs: mode 0 and mode 3 slaves driven by a behavioural SPI master, checked against a frame-level model
module tb_spi_slave_regs;
  localparam int HALF = 60;
`ifdef SPI_SLAVE_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic s = 1'b0, ss_n = 1'b1, mosi = 1'b0, m3 = 1'b0;
  logic [7:0] rdata = 8'h00;
  int checks = 0, errors = 0;
  int n_wr = 0, n_rd = 0, n_err = 0, n_err_long = 0;
  logic err_q = 1'b0;
  logic [6:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;
  logic [6:0] exp_addr [2];
  logic [7:0] exp_wdata [2];
  logic o_wr, o_rd, o_err, o_miso, o_oe;
  logic [6:0] o_addr;
  logic [7:0] o_wdata;
  spi_slave_regs_if if0();
  spi_slave_regs_if if3();
  spi_slave_regs #(.CPOL(1'b0), .CPHA(1'b0)) u_m0 (.PCLK(PCLK), .PRESETn(PRESETn), .bus(if0));
  spi_slave_regs #(.CPOL(1'b1), .CPHA(1'b1)) u_m3 (.PCLK(PCLK), .PRESETn(PRESETn), .bus(if3));
  assign if0.SCLK = m3 ? 1'b0 : s;
  assign if0.SS_n = m3 ? 1'b1 : ss_n;
  assign if0.MOSI = mosi;
  assign if0.rdata = rdata;
  assign if3.SCLK = m3 ? ~s : 1'b1;
  assign if3.SS_n = m3 ? ss_n : 1'b1;
  assign if3.MOSI = mosi;
  assign if3.rdata = rdata;
  assign o_wr = m3 ? if3.wr_en : if0.wr_en;
  assign o_rd = m3 ? if3.rd_en : if0.rd_en;
  assign o_err = m3 ? if3.err : if0.err;
  assign o_miso = m3 ? if3.MISO : if0.MISO;
  assign o_oe = m3 ? if3.miso_oe : if0.miso_oe;
  assign o_addr = m3 ? if3.addr : if0.addr;
  assign o_wdata = m3 ? if3.wdata : if0.wdata;
  always #5 PCLK = ~PCLK;
  always @(negedge PCLK) begin
    if (o_wr) begin
      n_wr++;
      wr_addr = o_addr;
      wr_data = o_wdata;
    end
    if (o_rd) begin
      n_rd++;
      rd_addr = o_addr;
    end
    if (o_err) n_err++;
    if (o_err && err_q) n_err_long++;
    err_q = o_err;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic reset_check();
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("rst_wr", o_wr, 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_err", o_err, 0);
    chk("rst_miso", o_miso, 0);
    chk("rst_oe", o_oe, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_wdata", o_wdata, 0);
    PRESETn = 1'b1;
    exp_addr[0] = '0;
    exp_addr[1] = '0;
    exp_wdata[0] = '0;
    exp_wdata[1] = '0;
  endtask
  // bits[31] is the first bit on the wire; rst_at >= 0 pulses PRESETn before that bit
  task automatic frame(input logic mode3, input logic [31:0] bits, input int n,
                       input logic [7:0] rd_val, input int rst_at);
    int wr0, rd0, er0, el0, e_wr, e_rd, e_err;
    logic [7:0] rx, d;
    logic [6:0] a;
    logic rw;
    m3 = mode3;
    rdata = rd_val;
    rx = '0;
    repeat (4) @(negedge PCLK);
    wr0 = n_wr;
    rd0 = n_rd;
    er0 = n_err;
    el0 = n_err_long;
    ss_n = 1'b0;
    if (!mode3) mosi = bits[31];
    #HALF;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) reset_check();
      if (i == 4) chk("oe_active", o_oe, 1);
      if (!mode3) begin
        if (i >= 8 && i < 16) rx = {rx[6:0], o_miso};
        s = 1'b1;
        #HALF;
        s = 1'b0;
        mosi = bits[30 - i];
        #HALF;
      end else begin
        s = 1'b1;
        mosi = bits[31 - i];
        #HALF;
        if (i >= 8 && i < 16) rx = {rx[6:0], o_miso};
        s = 1'b0;
        #HALF;
      end
    end
    ss_n = 1'b1;
    repeat (20) @(negedge PCLK);
    rw = bits[31];
    a = bits[30:24];
    d = bits[23:16];
    if (rst_at >= 0) begin
      e_wr = 0;
      e_rd = 0;
      e_err = 0;
    end else begin
      e_wr = (n >= 16 && !rw) ? 1 : 0;
      e_rd = (n >= 8 && rw && READ_EN) ? 1 : 0;
      e_err = (n != 16 || (rw && !READ_EN)) ? 1 : 0;
      if (n >= 8) exp_addr[mode3] = a;
      if (e_wr != 0) exp_wdata[mode3] = d;
    end
    chk("wr_cnt", n_wr - wr0, e_wr);
    chk("rd_cnt", n_rd - rd0, e_rd);
    chk("err_cnt", n_err - er0, e_err);
    chk("err_width", n_err_long - el0, 0);
    if (e_wr != 0) begin
      chk("wr_addr", wr_addr, a);
      chk("wr_data", wr_data, d);
    end
    if (e_rd != 0) chk("rd_addr", rd_addr, a);
    if (n >= 16 && rst_at < 0) chk("miso_byte", rx, (rw && READ_EN) ? rd_val : 8'h00);
    chk("addr_hold", o_addr, exp_addr[mode3]);
    chk("wdata_hold", o_wdata, exp_wdata[mode3]);
    chk("oe_idle", o_oe, 0);
  endtask
  initial begin
    reset_check();
    repeat (10) @(negedge PCLK);
    frame(1'b0, {8'h15, 8'hA5, 16'h0}, 16, 8'h00, -1);
    frame(1'b0, {8'h95, 8'h00, 16'h0}, 16, 8'h3C, -1);
    frame(1'b1, {8'h7F, 8'h00, 16'h0}, 16, 8'h00, -1);
    frame(1'b1, {8'h80, 8'h00, 16'h0}, 16, 8'hFF, -1);
    frame(1'b0, {8'h0A, 8'hC3, 16'h0}, 11, 8'h00, -1);
    frame(1'b0, {8'h01, 8'h5A, 16'h0}, 16, 8'h00, -1);
    frame(1'b0, {8'h02, 8'h11, 16'hC000}, 18, 8'h00, -1);
    frame(1'b0, {8'h04, 8'h66, 16'h0}, 16, 8'h00, 11);
    frame(1'b0, {8'h03, 8'h22, 16'h0}, 16, 8'h00, -1);
    for (int k = 0; k < 24; k++) begin
      logic [31:0] b;
      int n;
      b = $urandom;
      n = ($urandom_range(0, 2) != 0) ? 16 : int'($urandom_range(3, 20));
      frame(1'($urandom_range(0, 1)), b, n, 8'($urandom), -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
